multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the RV32I core.
- Drives the fetch handshake, enables the instruction decoder for one cycle, classifies the decoder's 48-bit one-hot inst_flags, and issues per-cycle datapath controls: PC update, register write-back, data-memory handshake, CSR write, trap entry and WFI sleep.
- Sits between the instruction/data memory ports and the decoder/regfile/ALU/CSR datapath.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem_ack/dmem_ack before an access-fault trap (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request, held until ack
imem_ack  in  1  fetch data valid this cycle
ir_we  out  1  load instruction register
dec_en  out  1  decoder enable
inst_flags  in  48  decoder one-hot flags; bit0 beq .. bit47 wfi
invalid_instruction  in  1  decoder illegal flag, valid only while dec_en=1
branch_cond  in  1  datapath comparator result for current branch
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  1=store, 0=load; valid with dmem_req
dmem_ack  in  1  data access complete
rf_we  out  1  regfile write strobe
wb_sel  out  2  0=ALU, 1=mem, 2=PC+4, 3=CSR read data
pc_we  out  1  PC write strobe
pc_sel  out  2  0=PC+4, 1=PC+imm, 2=rs1+imm (jalr), 3=trap vector/xEPC
csr_we  out  1  CSR write strobe
trap_valid  out  1  one-cycle trap entry pulse
trap_cause  out  4  mcause code, valid with trap_valid
irq  in  1  pending interrupt (wakes WFI)
retire  out  1  one-cycle instruction-retired pulse
instret  out  CNT_W  retired-instruction count

Behaviour:
- Flag classes, by inst_flags bit:
  - BR: [5:0]
  - JALR: 6
  - JAL: 7
  - UP: 8, 28
  - ALUI: [17:9]
  - ALUR: [27:18]
  - LD: [33:29]
  - ST: [36:34]
  - CSR: [42:37]
  - EBREAK: 43
  - ECALL: 44
  - MRET/SRET: 45, 46
  - WFI: 47
- Class is registered in DECODE and held through the instruction.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WFI, TRAP.
- Reset (async, rst_n=0):
  - state=IDLE, instret=0, timeout counter=0, class reg=0.
  - All outputs 0.
  - IDLE -> FETCH on the first clock after release.
  - Reset mid-operation aborts immediately: no retire, no PC write.
- Outputs are combinational from state, class reg and ack inputs.
- FETCH:
  - imem_req=1. On imem_ack: ir_we=1 same cycle -> DECODE.
  - Counter increments on each cycle without ack. Counter reaching MEM_TIMEOUT -> TRAP, cause 1.
- DECODE:
  - dec_en=1; class reg loaded.
  - invalid_instruction=1, or inst_flags==0 (all-zero word, malformed jalr) -> TRAP, cause 2.
  - More than one flag set: not checked (decoder guarantees one-hot).
  - Otherwise -> EXEC.
- EXEC (one cycle, then FETCH unless noted):
  - BR: pc_we=1, pc_sel=branch_cond?1:0.
  - JAL: rf_we, wb_sel=2, pc_we, pc_sel=1.
  - JALR: rf_we, wb_sel=2, pc_we, pc_sel=2.
  - UP/ALUI/ALUR: rf_we, wb_sel=0, pc_we, pc_sel=0.
  - CSR: rf_we, wb_sel=3, csr_we, pc_we, pc_sel=0.
  - LD/ST: no strobes -> MEM.
  - ECALL: -> TRAP, cause 11.
  - EBREAK: -> TRAP, cause 3.
  - MRET/SRET: pc_we, pc_sel=3, retire.
  - WFI: -> WFI.
- MEM:
  - dmem_req=1; dmem_we=1 for ST.
  - On dmem_ack:
    - LD: rf_we, wb_sel=1.
    - Both LD and ST: pc_we, pc_sel=0 -> FETCH.
  - Counter reaching MEM_TIMEOUT with no ack -> TRAP, cause 5 (LD) / 7 (ST), with no rf_we.
- Timeout counter clears on every state entry.
- WFI:
  - Hold with no strobes while irq=0.
  - irq=1: pc_we, pc_sel=0, retire -> FETCH. irq already high on entry wakes on the first WFI cycle.
- TRAP:
  - One cycle: trap_valid=1, trap_cause held, pc_we=1, pc_sel=3 -> FETCH.
  - No retire, rf_we=0, csr_we=0 (the CSR file captures mepc/mcause on trap_valid).
- retire pulses exactly in the cycle an instruction's final pc_we fires outside TRAP.
- instret += 1 on retire; wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - ALU/branch/jump/CSR: 3 cycles.
  - Load/store: 4 cycles.
- Simultaneous ack and timeout in the same cycle: ack wins.

Test Plan:
- addi fetched with imem_ack in 1st FETCH cycle -> DECODE, then EXEC; rf_we=1, wb_sel=0, pc_sel=0; retire at cycle 3; instret 0->1.
- beq with branch_cond=1, then bne with branch_cond=0 -> pc_sel=1, then pc_sel=0; rf_we=0 both; instret +2.
- lw, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0; rf_we with wb_sel=1 in ack cycle; 7 cycles total.
- sw with dmem_ack never, MEM_TIMEOUT=16 -> TRAP after 16 MEM cycles; trap_cause=7, pc_sel=3; no retire, rf_we never 1.
- invalid_instruction=1 in DECODE, then ecall -> trap_cause=2, then 11; each trap_valid exactly 1 cycle; instret unchanged.
- wfi with irq low 10 cycles then high -> no strobes while low; pc_we+retire in irq cycle. Assert rst_n=0 mid-MEM -> dmem_req drops asynchronously; IDLE, then FETCH after release; instret=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Bus bundle between the multi-cycle controller and its memories/datapath.
//
// Handshake rule for both memory ports: the controller raises *_req and
// holds it high, together with any qualifiers such as dmem_we, until the
// cycle in which *_ack is sampled high. The transfer completes in that
// ack cycle, and req may drop on the next cycle. An ack seen while req is
// low is ignored.
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   // fetch port
   logic             imem_req;
   logic             imem_ack;
   logic             ir_we;
   // decoder
   logic             dec_en;
   logic [47:0]      inst_flags;
   logic             invalid_instruction;
   logic             branch_cond;
   // data memory port
   logic             dmem_req;
   logic             dmem_we;
   logic             dmem_ack;
   // datapath strobes
   logic             rf_we;
   logic [1:0]       wb_sel;
   logic             pc_we;
   logic [1:0]       pc_sel;
   logic             csr_we;
   logic             trap_valid;
   logic [3:0]       trap_cause;
   logic             irq;
   logic             retire;
   logic [CNT_W-1:0] instret;
   // current FSM state, for debug and checkers
   logic [2:0]       dbg_state;

   modport master (
      output imem_req, ir_we, dec_en, dmem_req, dmem_we, rf_we, wb_sel,
             pc_we, pc_sel, csr_we, trap_valid, trap_cause, retire,
             instret, dbg_state,
      input  imem_ack, inst_flags, invalid_instruction, branch_cond,
             dmem_ack, irq
   );

   modport slave (
      input  imem_req, ir_we, dec_en, dmem_req, dmem_we, rf_we, wb_sel,
             pc_we, pc_sel, csr_we, trap_valid, trap_cause, retire,
             instret, dbg_state,
      output imem_ack, inst_flags, invalid_instruction, branch_cond,
             dmem_ack, irq
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing FSM for the RV32I core. It fetches, enables the
// decoder for one cycle, classifies the one-hot decoder flags, and then
// issues the per-cycle PC, write-back, memory, CSR, trap and WFI controls.
// All outputs are combinational from the state, the class register and the
// ack/irq inputs.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   multicycle_controller_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WFI    = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      C_NONE   = 4'd0,
      C_BR     = 4'd1,
      C_JALR   = 4'd2,
      C_JAL    = 4'd3,
      C_ALU    = 4'd4,   // upper-immediate, ALU-immediate and ALU-register
      C_LD     = 4'd5,
      C_ST     = 4'd6,
      C_CSR    = 4'd7,
      C_EBREAK = 4'd8,
      C_ECALL  = 4'd9,
      C_XRET   = 4'd10,  // mret / sret
      C_WFI    = 4'd11
   } cls_e;

   // mcause codes raised by the controller
   localparam logic [3:0] CAUSE_IFETCH = 4'd1;
   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
   localparam logic [3:0] CAUSE_BREAK  = 4'd3;
   localparam logic [3:0] CAUSE_LD_ACC = 4'd5;
   localparam logic [3:0] CAUSE_ST_ACC = 4'd7;
   localparam logic [3:0] CAUSE_ECALL  = 4'd11;

   // write-back and PC source selects
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_CSR = 2'd3;
   localparam logic [1:0] PC_SEQ  = 2'd0;
   localparam logic [1:0] PC_REL  = 2'd1;
   localparam logic [1:0] PC_JALR = 2'd2;
   localparam logic [1:0] PC_TRAP = 2'd3;

   // The wait counter holds the number of ack-less cycles already spent
   // in the current state; a miss while it sits at TO_LAST is the
   // MEM_TIMEOUT-th miss and ends the wait with a trap.
   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   cls_e              cls_q, cls_d;
   cls_e              flag_cls;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        cause_q, cause_d;
   logic [CNT_W-1:0]  instret_q, instret_d;

   logic              imem_req;
   logic              ir_we;
   logic              dec_en;
   logic              dmem_req;
   logic              dmem_we;
   logic              rf_we;
   logic [1:0]        wb_sel;
   logic              pc_we;
   logic [1:0]        pc_sel;
   logic              csr_we;
   logic              trap_valid;
   logic [3:0]        trap_cause;
   logic              retire;

   // Map the decoder's one-hot flags onto an instruction class.
   always_comb begin
      flag_cls = C_NONE;
      if (|bus.inst_flags[5:0]) begin
         flag_cls = C_BR;
      end else if (bus.inst_flags[6]) begin
         flag_cls = C_JALR;
      end else if (bus.inst_flags[7]) begin
         flag_cls = C_JAL;
      end else if (bus.inst_flags[8] || bus.inst_flags[28] ||
                   (|bus.inst_flags[27:9])) begin
         flag_cls = C_ALU;
      end else if (|bus.inst_flags[33:29]) begin
         flag_cls = C_LD;
      end else if (|bus.inst_flags[36:34]) begin
         flag_cls = C_ST;
      end else if (|bus.inst_flags[42:37]) begin
         flag_cls = C_CSR;
      end else if (bus.inst_flags[43]) begin
         flag_cls = C_EBREAK;
      end else if (bus.inst_flags[44]) begin
         flag_cls = C_ECALL;
      end else if (bus.inst_flags[45] || bus.inst_flags[46]) begin
         flag_cls = C_XRET;
      end else if (bus.inst_flags[47]) begin
         flag_cls = C_WFI;
      end
   end

   // Next-state, class/cause capture, wait counter and datapath strobes.
   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      cause_d    = cause_q;
      cnt_d      = 8'd0;       // cleared on every state entry
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      dec_en     = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = WB_ALU;
      pc_we      = 1'b0;
      pc_sel     = PC_SEQ;
      csr_we     = 1'b0;
      trap_valid = 1'b0;
      trap_cause = 4'd0;
      retire     = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end

         S_FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ack) begin
               // an ack in the timeout cycle still wins
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (cnt_q == TO_LAST) begin
               cause_d = CAUSE_IFETCH;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_DECODE: begin
            dec_en = 1'b1;
            cls_d  = flag_cls;
            if (bus.invalid_instruction || (bus.inst_flags == 48'd0)) begin
               cause_d = CAUSE_ILLEGAL;
               state_d = S_TRAP;
            end else begin
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            state_d = S_FETCH;
            case (cls_q)
               C_BR: begin
                  pc_we  = 1'b1;
                  pc_sel = bus.branch_cond ? PC_REL : PC_SEQ;
                  retire = 1'b1;
               end
               C_JAL: begin
                  rf_we  = 1'b1;
                  wb_sel = WB_PC4;
                  pc_we  = 1'b1;
                  pc_sel = PC_REL;
                  retire = 1'b1;
               end
               C_JALR: begin
                  rf_we  = 1'b1;
                  wb_sel = WB_PC4;
                  pc_we  = 1'b1;
                  pc_sel = PC_JALR;
                  retire = 1'b1;
               end
               C_ALU: begin
                  rf_we  = 1'b1;
                  wb_sel = WB_ALU;
                  pc_we  = 1'b1;
                  pc_sel = PC_SEQ;
                  retire = 1'b1;
               end
               C_CSR: begin
                  rf_we  = 1'b1;
                  wb_sel = WB_CSR;
                  csr_we = 1'b1;
                  pc_we  = 1'b1;
                  pc_sel = PC_SEQ;
                  retire = 1'b1;
               end
               C_LD, C_ST: begin
                  state_d = S_MEM;
               end
               C_ECALL: begin
                  cause_d = CAUSE_ECALL;
                  state_d = S_TRAP;
               end
               C_EBREAK: begin
                  cause_d = CAUSE_BREAK;
                  state_d = S_TRAP;
               end
               C_XRET: begin
                  pc_we  = 1'b1;
                  pc_sel = PC_TRAP;
                  retire = 1'b1;
               end
               C_WFI: begin
                  state_d = S_WFI;
               end
               default: begin
                  // unreachable: DECODE traps on an empty flag word
                  state_d = S_FETCH;
               end
            endcase
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == C_ST);
            if (bus.dmem_ack) begin
               if (cls_q == C_LD) begin
                  rf_we  = 1'b1;
                  wb_sel = WB_MEM;
               end
               pc_we   = 1'b1;
               pc_sel  = PC_SEQ;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (cnt_q == TO_LAST) begin
               cause_d = (cls_q == C_ST) ? CAUSE_ST_ACC : CAUSE_LD_ACC;
               state_d = S_TRAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         S_WFI: begin
            if (bus.irq) begin
               pc_we   = 1'b1;
               pc_sel  = PC_SEQ;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end

         S_TRAP: begin
            // the CSR file captures mepc/mcause from this pulse
            trap_valid = 1'b1;
            trap_cause = cause_q;
            pc_we      = 1'b1;
            pc_sel     = PC_TRAP;
            state_d    = S_FETCH;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Retired-instruction counter, wrapping at 2^CNT_W.
   always_comb begin
      instret_d = instret_q;
      if (retire) begin
         instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // State, class, cause, wait counter and instret registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cls_q     <= C_NONE;
         cnt_q     <= 8'd0;
         cause_q   <= 4'd0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         cnt_q     <= cnt_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end

   assign bus.imem_req   = imem_req;
   assign bus.ir_we      = ir_we;
   assign bus.dec_en     = dec_en;
   assign bus.dmem_req   = dmem_req;
   assign bus.dmem_we    = dmem_we;
   assign bus.rf_we      = rf_we;
   assign bus.wb_sel     = wb_sel;
   assign bus.pc_we      = pc_we;
   assign bus.pc_sel     = pc_sel;
   assign bus.csr_we     = csr_we;
   assign bus.trap_valid = trap_valid;
   assign bus.trap_cause = trap_cause;
   assign bus.retire     = retire;
   assign bus.instret    = instret_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. A transaction-level model expands each
// instruction (class, fetch/mem wait counts, branch outcome, irq delay)
// into the per-cycle inputs to drive and the outputs the controller must
// show, and the driver replays both queues cycle by cycle.
module tb_multicycle_controller;

   localparam int TO    = 16;
   localparam int CNT_W = 32;

   // instruction kinds used by the model
   localparam int K_NONE = 0, K_BR = 1, K_JALR = 2, K_JAL = 3, K_ALU = 4,
                  K_LD = 5, K_ST = 6, K_CSR = 7, K_EBREAK = 8, K_ECALL = 9,
                  K_XRET = 10, K_WFI = 11;

   typedef struct packed {
      logic       imem_req;
      logic       ir_we;
      logic       dec_en;
      logic       dmem_req;
      logic       dmem_we;
      logic       rf_we;
      logic [1:0] wb_sel;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       csr_we;
      logic       trap_valid;
      logic [3:0] trap_cause;
      logic       retire;
   } ov_t;

   typedef struct packed {
      logic        imem_ack;
      logic        invalid;
      logic        branch_cond;
      logic        dmem_ack;
      logic        irq;
      logic [47:0] flags;
   } iv_t;

   localparam int OW = $bits(ov_t);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   iv_t              in_q[$];
   logic [OW-1:0]    exp_q[$];
   logic [CNT_W-1:0] cnt_exp_q[$];
   logic [CNT_W-1:0] m_instret;
   logic [47:0]      cur_flags;
   int               n_cmp = 0;
   int               n_err = 0;

   // clock / reset
   always #5 clk = ~clk;

   multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

   multicycle_controller #(
      .MEM_TIMEOUT(TO),
      .CNT_W      (CNT_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic ov_t obs();
      ov_t o;
      o.imem_req   = bus.imem_req;
      o.ir_we      = bus.ir_we;
      o.dec_en     = bus.dec_en;
      o.dmem_req   = bus.dmem_req;
      o.dmem_we    = bus.dmem_we;
      o.rf_we      = bus.rf_we;
      o.wb_sel     = bus.wb_sel;
      o.pc_we      = bus.pc_we;
      o.pc_sel     = bus.pc_sel;
      o.csr_we     = bus.csr_we;
      o.trap_valid = bus.trap_valid;
      o.trap_cause = bus.trap_cause;
      o.retire     = bus.retire;
      return o;
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // instruction class of a flag bit, straight from the opcode table
   function automatic int cls_of(input int b);
      if (b < 0)                 return K_NONE;
      if (b <= 5)                return K_BR;
      if (b == 6)                return K_JALR;
      if (b == 7)                return K_JAL;
      if (b == 8 || b == 28)     return K_ALU;
      if (b >= 9 && b <= 27)     return K_ALU;
      if (b >= 29 && b <= 33)    return K_LD;
      if (b >= 34 && b <= 36)    return K_ST;
      if (b >= 37 && b <= 42)    return K_CSR;
      if (b == 43)               return K_EBREAK;
      if (b == 44)               return K_ECALL;
      if (b == 45 || b == 46)    return K_XRET;
      return K_WFI;
   endfunction

   // don't-care inputs are randomised; callers pin the ones that matter
   function automatic iv_t rnd_in();
      iv_t i;
      i.imem_ack    = 1'($urandom_range(0, 1));
      i.invalid     = 1'($urandom_range(0, 1));
      i.branch_cond = 1'($urandom_range(0, 1));
      i.dmem_ack    = 1'($urandom_range(0, 1));
      i.irq         = 1'($urandom_range(0, 1));
      i.flags       = cur_flags;
      return i;
   endfunction

   task automatic push(input iv_t i, input ov_t o);
      in_q.push_back(i);
      exp_q.push_back(o);
      cnt_exp_q.push_back(m_instret);
      if (o.retire) m_instret = m_instret + 1;
   endtask

   task automatic push_trap(input logic [3:0] cause);
      ov_t o = '0;
      o.trap_valid = 1'b1;
      o.trap_cause = cause;
      o.pc_we      = 1'b1;
      o.pc_sel     = 2'd3;
      push(rnd_in(), o);
   endtask

   // model: expand one instruction into its cycle-by-cycle expectation
   task automatic add_instr(input int b, input int fw, input int mw,
                            input bit bc, input bit inv, input int iw);
      iv_t i;
      ov_t o;
      int  kind = cls_of(b);
      bit  st   = (kind == K_ST);
      cur_flags = '0;
      if (b >= 0) cur_flags[b] = 1'b1;
      // fetch
      for (int k = 0; k < ((fw < TO) ? fw : TO); k++) begin
         i = rnd_in(); i.imem_ack = 1'b0;
         o = '0; o.imem_req = 1'b1;
         push(i, o);
      end
      if (fw >= TO) begin push_trap(4'd1); return; end
      i = rnd_in(); i.imem_ack = 1'b1;
      o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1;
      push(i, o);
      // decode
      i = rnd_in(); i.invalid = inv;
      o = '0; o.dec_en = 1'b1;
      push(i, o);
      if (inv || b < 0) begin push_trap(4'd2); return; end
      // execute
      i = rnd_in(); i.branch_cond = bc;
      o = '0;
      case (kind)
         K_BR:   begin o.pc_we = 1; o.pc_sel = bc ? 2'd1 : 2'd0; o.retire = 1; end
         K_JAL:  begin o.rf_we = 1; o.wb_sel = 2; o.pc_we = 1; o.pc_sel = 1; o.retire = 1; end
         K_JALR: begin o.rf_we = 1; o.wb_sel = 2; o.pc_we = 1; o.pc_sel = 2; o.retire = 1; end
         K_ALU:  begin o.rf_we = 1; o.wb_sel = 0; o.pc_we = 1; o.pc_sel = 0; o.retire = 1; end
         K_CSR:  begin o.rf_we = 1; o.wb_sel = 3; o.csr_we = 1; o.pc_we = 1; o.retire = 1; end
         K_XRET: begin o.pc_we = 1; o.pc_sel = 3; o.retire = 1; end
         default: ;
      endcase
      push(i, o);
      if (kind == K_ECALL)  begin push_trap(4'd11); return; end
      if (kind == K_EBREAK) begin push_trap(4'd3);  return; end
      if (kind == K_LD || kind == K_ST) begin
         for (int k = 0; k < ((mw < TO) ? mw : TO); k++) begin
            i = rnd_in(); i.dmem_ack = 1'b0;
            o = '0; o.dmem_req = 1'b1; o.dmem_we = st;
            push(i, o);
         end
         if (mw >= TO) begin push_trap(st ? 4'd7 : 4'd5); return; end
         i = rnd_in(); i.dmem_ack = 1'b1;
         o = '0; o.dmem_req = 1'b1; o.dmem_we = st;
         if (!st) begin o.rf_we = 1'b1; o.wb_sel = 2'd1; end
         o.pc_we = 1'b1; o.retire = 1'b1;
         push(i, o);
      end
      if (kind == K_WFI) begin
         for (int k = 0; k < iw; k++) begin
            i = rnd_in(); i.irq = 1'b0;
            push(i, '0);
         end
         i = rnd_in(); i.irq = 1'b1;
         o = '0; o.pc_we = 1'b1; o.retire = 1'b1;
         push(i, o);
      end
   endtask

   task automatic drive(input iv_t i);
      bus.imem_ack            = i.imem_ack;
      bus.invalid_instruction = i.invalid;
      bus.branch_cond         = i.branch_cond;
      bus.dmem_ack            = i.dmem_ack;
      bus.irq                 = i.irq;
      bus.inst_flags          = i.flags;
   endtask

   // driver + scoreboard: called at a falling edge, returns at one
   task automatic play(input int n);
      for (int k = 0; k < n && in_q.size() > 0; k++) begin
         drive(in_q.pop_front());
         #1;
         chk("outputs", 64'(obs()), 64'(exp_q.pop_front()));
         chk("instret", 64'(bus.instret), 64'(cnt_exp_q.pop_front()));
         @(negedge clk);
      end
   endtask

   task automatic rand_instr();
      int r;
      int b  = $urandom_range(0, 48);
      int fw, mw;
      if (b == 48) b = -1;
      r  = $urandom_range(0, 9);
      fw = (r < 7) ? r % 3 : ((r == 7) ? TO - 1 : ((r == 8) ? TO : 0));
      r  = $urandom_range(0, 9);
      mw = (r < 7) ? r % 4 : ((r == 7) ? TO - 1 : ((r == 8) ? TO : 1));
      add_instr(b, fw, mw, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0), $urandom_range(0, 4));
   endtask

   initial begin
      cur_flags = '0;
      m_instret = '0;
      drive('0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", 64'(obs()), 64'(0));
      chk("reset_instret", 64'(bus.instret), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_outputs", 64'(obs()), 64'(0));
      @(negedge clk);

      // directed steps
      add_instr(9, 0, 0, 0, 0, 0);          // addi
      add_instr(0, 0, 0, 1, 0, 0);          // beq taken
      add_instr(1, 0, 0, 0, 0, 0);          // bne not taken
      add_instr(29, 0, 3, 0, 0, 0);         // lw, 3 wait cycles
      add_instr(34, 0, TO, 0, 0, 0);        // sw, never acked
      add_instr(9, 0, 0, 0, 1, 0);          // illegal instruction
      add_instr(44, 0, 0, 0, 0, 0);         // ecall
      add_instr(47, 0, 0, 0, 0, 10);        // wfi, irq after 10 cycles
      add_instr(47, 0, 0, 0, 0, 0);         // wfi, irq on first cycle
      add_instr(18, TO - 1, 0, 0, 0, 0);    // fetch ack in the timeout cycle
      add_instr(18, TO, 0, 0, 0, 0);        // fetch timeout
      add_instr(-1, 1, 0, 0, 0, 0);         // all-zero flag word
      add_instr(30, 2, TO - 1, 0, 0, 0);    // load ack in the timeout cycle
      add_instr(31, 0, TO, 0, 0, 0);        // load timeout
      add_instr(35, 1, 0, 0, 0, 0);         // store, zero wait
      add_instr(43, 0, 0, 0, 0, 0);         // ebreak
      add_instr(7, 0, 0, 0, 0, 0);          // jal
      add_instr(6, 0, 0, 0, 0, 0);          // jalr
      add_instr(37, 0, 0, 0, 0, 0);         // csr
      add_instr(45, 0, 0, 0, 0, 0);         // mret
      add_instr(46, 0, 0, 0, 0, 0);         // sret
      add_instr(8, 0, 0, 0, 0, 0);          // lui
      add_instr(28, 0, 0, 0, 0, 0);         // auipc
      play(in_q.size());

      // randomized instruction stream
      for (int n = 0; n < 60; n++) rand_instr();
      play(in_q.size());
      #1;
      chk("instret_total", 64'(bus.instret), 64'(m_instret));

      // reset in the middle of a load that is never acked
      add_instr(29, 0, TO, 0, 0, 0);
      play(5);                              // fetch, decode, exec, 2 mem
      drive(in_q.pop_front());
      #1;
      chk("mem_req_before_reset", 64'(bus.dmem_req), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mem_req_async_drop", 64'(bus.dmem_req), 64'(0));
      chk("abort_outputs", 64'(obs()), 64'(0));
      chk("abort_instret", 64'(bus.instret), 64'(0));
      in_q.delete();
      exp_q.delete();
      cnt_exp_q.delete();
      m_instret = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_after_reset", 64'(obs()), 64'(0));
      @(negedge clk);
      add_instr(12, 0, 0, 0, 0, 0);
      play(in_q.size());
      #1;
      chk("instret_after_reset", 64'(bus.instret), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
